// File: rtl/riscv_fetch_stage_pkg.sv
// Shared types and constants for the RV32I instruction fetch stage.
// Provides the IF/ID register layout, the fetch FSM encoding and the bubble word.
package riscv_fetch_stage_pkg;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_reg_t;

    // addi x0,x0,0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Sequential fetch address; wraps modulo 2^32 by construction.
    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/riscv_fetch_stage_if.sv
// Fetch-stage bundle: instruction memory handshake, hazard/redirect controls and IF/ID output.
// The master modport is the fetch stage; the slave modport is memory plus the rest of the core.
interface riscv_fetch_stage_if;
    import riscv_fetch_stage_pkg::*;

    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    if_id_reg_t  if_id_o;
    logic        if_id_valid_o;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_gnt_i,
        input  imem_rvalid_i,
        input  imem_rdata_i,
        input  stall_i,
        input  redirect_i,
        input  redirect_pc_i,
        output if_id_o,
        output if_id_valid_o
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_gnt_i,
        output imem_rvalid_i,
        output imem_rdata_i,
        output stall_i,
        output redirect_i,
        output redirect_pc_i,
        input  if_id_o,
        input  if_id_valid_o
    );

endinterface

// File: rtl/riscv_fetch_stage.sv
// Non-pipelined instruction fetch: one outstanding word request, IF/ID register,
// a one-entry hold buffer for stalled responses and a drain state to kill stale responses.
module riscv_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = riscv_fetch_stage_pkg::NOP_INSTR
) (
    input  logic                  clk,
    input  logic                  rst_n,
    riscv_fetch_stage_if.master   fetch
);
    import riscv_fetch_stage_pkg::*;

    fetch_state_t state_q, state_n;
    logic [31:0]  pc_q, pc_n;
    if_id_reg_t   hold_q, hold_n;
    if_id_reg_t   if_id_q, if_id_n;
    logic         vld_q, vld_n;
    logic         if_id_free;

    // Low address bits of the redirect target are discarded by alignment.
    logic unused_redirect_lsb;
    assign unused_redirect_lsb = ^fetch.redirect_pc_i[1:0];

    assign fetch.imem_req_o    = rst_n && (state_q == S_REQ);
    assign fetch.imem_addr_o   = pc_q;
    assign fetch.if_id_o       = if_id_q;
    assign fetch.if_id_valid_o = vld_q;

    assign if_id_free = !vld_q || !fetch.stall_i;

    always_comb begin
        state_n = state_q;
        pc_n    = pc_q;
        hold_n  = hold_q;
        if_id_n = if_id_q;
        vld_n   = vld_q;

        if (fetch.redirect_i) begin
            pc_n          = word_align(fetch.redirect_pc_i);
            if_id_n.instr = NOP_INSTR;
            vld_n         = 1'b0;
            hold_n        = '0;
            // A request already granted but not yet answered must be drained.
            unique case (state_q)
                S_REQ:   state_n = fetch.imem_gnt_i    ? S_DRAIN : S_REQ;
                S_WAIT:  state_n = fetch.imem_rvalid_i ? S_REQ   : S_DRAIN;
                S_HOLD:  state_n = S_REQ;
                S_DRAIN: state_n = fetch.imem_rvalid_i ? S_REQ   : S_DRAIN;
                default: state_n = S_REQ;
            endcase
        end else begin
            if (!fetch.stall_i) begin
                vld_n = 1'b0;
            end
            unique case (state_q)
                S_REQ: begin
                    if (fetch.imem_gnt_i) begin
                        state_n = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (fetch.imem_rvalid_i) begin
                        if (if_id_free) begin
                            if_id_n = '{pc: pc_q, instr: fetch.imem_rdata_i};
                            vld_n   = 1'b1;
                            pc_n    = pc_inc(pc_q);
                            state_n = S_REQ;
                        end else begin
                            hold_n  = '{pc: pc_q, instr: fetch.imem_rdata_i};
                            state_n = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!fetch.stall_i) begin
                        if_id_n = hold_q;
                        vld_n   = 1'b1;
                        pc_n    = pc_inc(pc_q);
                        state_n = S_REQ;
                    end
                end
                S_DRAIN: begin
                    if (fetch.imem_rvalid_i) begin
                        state_n = S_REQ;
                    end
                end
                default: state_n = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            hold_q  <= '0;
            if_id_q <= '{pc: 32'h0, instr: NOP_INSTR};
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            pc_q    <= pc_n;
            hold_q  <= hold_n;
            if_id_q <= if_id_n;
            vld_q   <= vld_n;
        end
    end

endmodule

// File: tb/tb_riscv_fetch_stage.sv
// Directed bench for riscv_fetch_stage: hand-sequenced memory handshake, stall, redirect,
// wrap-around and mid-fetch reset, checked with immediate assertions.
module tb_riscv_fetch_stage;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fails;

    riscv_fetch_stage_if fif ();

    riscv_fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0013)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .fetch (fif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst_n    = 1'b0;
        fif.imem_gnt_i    = 1'b0;
        fif.imem_rvalid_i = 1'b0;
        fif.imem_rdata_i  = 32'h0;
        fif.stall_i       = 1'b0;
        fif.redirect_i    = 1'b0;
        fif.redirect_pc_i = 32'h0;
        cyc();
        cyc();

        chk("rst_req",   64'(fif.imem_req_o), 64'd0);
        chk("rst_valid", 64'(fif.if_id_valid_o), 64'd0);
        chk("rst_if_id", fif.if_id_o, {32'h0, 32'h0000_0013});

        // First fetch at reset PC.
        rst_n = 1'b1;
        #1;
        chk("f0_req",  64'(fif.imem_req_o), 64'd1);
        chk("f0_addr", 64'(fif.imem_addr_o), 64'h0);
        fif.imem_gnt_i = 1'b1;
        cyc();
        chk("f0_wait_req", 64'(fif.imem_req_o), 64'd0);
        fif.imem_gnt_i    = 1'b0;
        fif.imem_rvalid_i = 1'b1;
        fif.imem_rdata_i  = 32'h0050_0093;
        cyc();
        fif.imem_rvalid_i = 1'b0;
        chk("f0_if_id",  fif.if_id_o, {32'h0, 32'h0050_0093});
        chk("f0_valid",  64'(fif.if_id_valid_o), 64'd1);
        chk("f0_next",   64'(fif.imem_addr_o), 64'h4);
        chk("f0_nreq",   64'(fif.imem_req_o), 64'd1);

        // Second fetch; IF/ID drains while decode is free.
        fif.imem_gnt_i = 1'b1;
        cyc();
        chk("f4_bubble", 64'(fif.if_id_valid_o), 64'd0);
        fif.imem_gnt_i    = 1'b0;
        fif.imem_rvalid_i = 1'b1;
        fif.imem_rdata_i  = 32'h0010_0113;
        cyc();
        fif.imem_rvalid_i = 1'b0;
        chk("f4_if_id", fif.if_id_o, {32'h4, 32'h0010_0113});
        chk("f4_next",  64'(fif.imem_addr_o), 64'h8);

        // Stall: response for 0x8 parks in the hold buffer.
        fif.stall_i    = 1'b1;
        fif.imem_gnt_i = 1'b1;
        cyc();
        chk("st_keep_valid", 64'(fif.if_id_valid_o), 64'd1);
        fif.imem_gnt_i    = 1'b0;
        fif.imem_rvalid_i = 1'b1;
        fif.imem_rdata_i  = 32'h0020_8193;
        cyc();
        fif.imem_rvalid_i = 1'b0;
        chk("st_hold_req",  64'(fif.imem_req_o), 64'd0);
        chk("st_hold_ifid", fif.if_id_o, {32'h4, 32'h0010_0113});
        cyc();
        chk("st_hold_req2", 64'(fif.imem_req_o), 64'd0);
        fif.stall_i = 1'b0;
        cyc();
        chk("st_rel_ifid",  fif.if_id_o, {32'h8, 32'h0020_8193});
        chk("st_rel_valid", 64'(fif.if_id_valid_o), 64'd1);
        chk("st_rel_addr",  64'(fif.imem_addr_o), 64'hC);
        chk("st_rel_req",   64'(fif.imem_req_o), 64'd1);

        // Redirect while waiting: the in-flight word is drained.
        fif.imem_gnt_i = 1'b1;
        cyc();
        fif.imem_gnt_i    = 1'b0;
        fif.redirect_i    = 1'b1;
        fif.redirect_pc_i = 32'h0000_0100;
        cyc();
        fif.redirect_i = 1'b0;
        chk("rd_drain_req", 64'(fif.imem_req_o), 64'd0);
        chk("rd_nop",       64'(fif.if_id_o[31:0]), 64'h13);
        chk("rd_valid",     64'(fif.if_id_valid_o), 64'd0);
        cyc();
        chk("rd_drain_req2", 64'(fif.imem_req_o), 64'd0);
        fif.imem_rvalid_i = 1'b1;
        fif.imem_rdata_i  = 32'hDEAD_BEEF;
        cyc();
        fif.imem_rvalid_i = 1'b0;
        chk("rd_stale_valid", 64'(fif.if_id_valid_o), 64'd0);
        chk("rd_req",         64'(fif.imem_req_o), 64'd1);
        chk("rd_addr",        64'(fif.imem_addr_o), 64'h100);
        fif.imem_gnt_i = 1'b1;
        cyc();
        fif.imem_gnt_i    = 1'b0;
        fif.imem_rvalid_i = 1'b1;
        fif.imem_rdata_i  = 32'h0000_0513;
        cyc();
        fif.imem_rvalid_i = 1'b0;
        chk("rd_tgt_ifid",  fif.if_id_o, {32'h100, 32'h0000_0513});
        chk("rd_tgt_valid", 64'(fif.if_id_valid_o), 64'd1);

        // Redirect coincident with rvalid: response dropped, target aligned.
        fif.imem_gnt_i = 1'b1;
        cyc();
        fif.imem_gnt_i    = 1'b0;
        fif.imem_rvalid_i = 1'b1;
        fif.imem_rdata_i  = 32'h1234_5678;
        fif.redirect_i    = 1'b1;
        fif.redirect_pc_i = 32'h0000_0103;
        cyc();
        fif.imem_rvalid_i = 1'b0;
        fif.redirect_i    = 1'b0;
        chk("rv_nop",   64'(fif.if_id_o[31:0]), 64'h13);
        chk("rv_valid", 64'(fif.if_id_valid_o), 64'd0);
        chk("rv_req",   64'(fif.imem_req_o), 64'd1);
        chk("rv_addr",  64'(fif.imem_addr_o), 64'h100);

        // Fetch from the top word, PC wraps to zero.
        fif.redirect_i    = 1'b1;
        fif.redirect_pc_i = 32'hFFFF_FFFC;
        cyc();
        fif.redirect_i = 1'b0;
        chk("wr_addr", 64'(fif.imem_addr_o), 64'hFFFF_FFFC);
        fif.imem_gnt_i = 1'b1;
        cyc();
        fif.imem_gnt_i    = 1'b0;
        fif.imem_rvalid_i = 1'b1;
        fif.imem_rdata_i  = 32'h0000_0073;
        cyc();
        fif.imem_rvalid_i = 1'b0;
        chk("wr_ifid", fif.if_id_o, {32'hFFFF_FFFC, 32'h0000_0073});
        chk("wr_next", 64'(fif.imem_addr_o), 64'h0);

        fif.imem_gnt_i = 1'b1;
        cyc();
        fif.imem_gnt_i    = 1'b0;
        fif.imem_rvalid_i = 1'b1;
        fif.imem_rdata_i  = 32'h0040_0193;
        cyc();
        fif.imem_rvalid_i = 1'b0;
        chk("w0_ifid", fif.if_id_o, {32'h0, 32'h0040_0193});

        // Grant withheld: request and address stay put.
        for (int i = 0; i < 5; i++) begin
            chk("gw_req",  64'(fif.imem_req_o), 64'd1);
            chk("gw_addr", 64'(fif.imem_addr_o), 64'h4);
            cyc();
        end

        // Reset during an outstanding fetch.
        fif.imem_gnt_i = 1'b1;
        cyc();
        fif.imem_gnt_i = 1'b0;
        chk("mr_wait_req", 64'(fif.imem_req_o), 64'd0);
        rst_n = 1'b0;
        #1;
        chk("mr_req_low", 64'(fif.imem_req_o), 64'd0);
        cyc();
        chk("mr_valid", 64'(fif.if_id_valid_o), 64'd0);
        chk("mr_ifid",  fif.if_id_o, {32'h0, 32'h0000_0013});
        rst_n = 1'b1;
        #1;
        chk("mr_req",  64'(fif.imem_req_o), 64'd1);
        chk("mr_addr", 64'(fif.imem_addr_o), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
